// File: rtl/counter_74163.sv
// Synchronous presettable binary counter (74163-style) with clear, load, count and ripple carry.
// Define COUNTER_74163_UPDOWN_EN to add the U_nD up/down control (74169-style terminal count).
module counter_74163 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             C,
   input  logic             nR,
   input  logic             nLOAD,
   input  logic             ENP,
   input  logic             ENT,
`ifdef COUNTER_74163_UPDOWN_EN
   input  logic             U_nD,
`endif
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             RCO
);

   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] terminal;
   logic             count_up;

`ifdef COUNTER_74163_UPDOWN_EN
   assign count_up = U_nD;
`else
   assign count_up = 1'b1;
`endif

   // Clear has priority over everything and is handled in the register itself.
   always_comb begin
      q_d = q_q;
      if (!nLOAD) begin
         q_d = D;
      end else if (ENP && ENT) begin
         q_d = count_up ? (q_q + One) : (q_q - One);
      end
   end

   always_ff @(posedge C) begin
      if (!nR) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   // Terminal value follows the count direction so cascaded stages borrow as well as carry.
   assign terminal = count_up ? '1 : '0;

   assign Q   = q_q;
   assign RCO = ENT && (q_q == terminal);

endmodule

// File: tb/tb_counter_74163.sv
// Self-checking bench for counter_74163: vector table, directed corner sequences,
// and randomized stimulus against an arithmetic reference model (single stage and 2-stage cascade).
module tb_counter_74163;

   logic       clk;
   logic       nr, nload, enp, ent, u_nd;
   logic [3:0] d;
   logic [3:0] q;
   logic       rco;

   logic       c_nr, c_nload, c_enp, c_ent;
   logic [7:0] c_d;
   logic [3:0] q_lo, q_hi;
   logic       rco_lo, rco_hi;

   int n_vec;
   int n_err;

   counter_74163 #(.WIDTH(4)) u_dut (
      .C    (clk),
      .nR   (nr),
      .nLOAD(nload),
      .ENP  (enp),
      .ENT  (ent),
`ifdef COUNTER_74163_UPDOWN_EN
      .U_nD (u_nd),
`endif
      .D    (d),
      .Q    (q),
      .RCO  (rco)
   );

   counter_74163 #(.WIDTH(4)) u_lo (
      .C    (clk),
      .nR   (c_nr),
      .nLOAD(c_nload),
      .ENP  (c_enp),
      .ENT  (c_ent),
`ifdef COUNTER_74163_UPDOWN_EN
      .U_nD (1'b1),
`endif
      .D    (c_d[3:0]),
      .Q    (q_lo),
      .RCO  (rco_lo)
   );

   counter_74163 #(.WIDTH(4)) u_hi (
      .C    (clk),
      .nR   (c_nr),
      .nLOAD(c_nload),
      .ENP  (c_enp),
      .ENT  (rco_lo),
`ifdef COUNTER_74163_UPDOWN_EN
      .U_nD (1'b1),
`endif
      .D    (c_d[7:4]),
      .Q    (q_hi),
      .RCO  (rco_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       nr;
      logic       nload;
      logic       enp;
      logic       ent;
      logic [3:0] d;
      logic [3:0] exp_q;
      logic       exp_rco;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: priority clear > load > count > hold, modulo arithmetic.
   function automatic int model_next(input int cur, input logic r, input logic l, input logic p,
                                     input logic t, input int din, input logic up, input int modv);
      if (!r) return 0;
      if (!l) return din;
      if (p && t) return up ? (cur + 1) % modv : (cur + modv - 1) % modv;
      return cur;
   endfunction

   int   model_q;
   int   model_c;
   logic exp_r;

   initial begin
      n_vec = 0;
      n_err = 0;
      u_nd  = 1'b1;
      nr = 1'b0; nload = 1'b1; enp = 1'b0; ent = 1'b0; d = 4'd0;
      c_nr = 1'b0; c_nload = 1'b1; c_enp = 1'b0; c_ent = 1'b0; c_d = 8'd0;
      #2;
      step();
      check("reset_q", q, 4'd0);
      check("reset_rco", rco, 1'b0);
      check("reset_cascade", {q_hi, q_lo}, 8'h00);

      //         nr    nload enp   ent   d      q      rco
      vecs = '{
         '{1'b1, 1'b0, 1'b0, 1'b0, 4'd13, 4'd13, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd14, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd15, 1'b1},
         '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd1,  1'b0},
         '{1'b1, 1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 1'b1},
         '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  4'd15, 1'b1},
         '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  4'd15, 1'b0},
         '{1'b1, 1'b0, 1'b0, 1'b0, 4'd10, 4'd10, 1'b0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  4'd0,  1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  4'd1,  1'b0},
         '{1'b0, 1'b1, 1'b0, 1'b0, 4'd7,  4'd0,  1'b0}
      };
      for (int i = 0; i < 12; i++) begin
         nr = vecs[i].nr; nload = vecs[i].nload; enp = vecs[i].enp; ent = vecs[i].ent;
         d  = vecs[i].d;
         step();
         check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
         check($sformatf("vec%0d_rco", i), rco, vecs[i].exp_rco);
      end

      // Clear is synchronous: asserting it between edges leaves Q alone.
      nr = 1'b1; nload = 1'b0; d = 4'd9; enp = 1'b0; ent = 1'b0;
      step();
      nr = 1'b0; nload = 1'b0; d = 4'd5; enp = 1'b1; ent = 1'b1;
      #3;
      check("clr_no_edge", q, 4'd9);
      step();
      check("clr_edge", q, 4'd0);

      // RCO follows ENT combinationally while Q holds at terminal.
      nr = 1'b1; nload = 1'b0; d = 4'd15; enp = 1'b0; ent = 1'b1;
      step();
      nload = 1'b1;
      step();
      check("hold_q15", q, 4'd15);
      check("hold_rco", rco, 1'b1);
      ent = 1'b0;
      #1;
      check("ent_drop_rco", rco, 1'b0);
      check("ent_drop_q", q, 4'd15);

`ifdef COUNTER_74163_UPDOWN_EN
      nload = 1'b0; d = 4'd1; ent = 1'b1; enp = 1'b1; u_nd = 1'b0;
      step();
      check("dn_load_rco", rco, 1'b0);
      nload = 1'b1;
      step();
      check("dn_q0", q, 4'd0);
      check("dn_rco0", rco, 1'b1);
      step();
      check("dn_q15", q, 4'd15);
      check("dn_rco15", rco, 1'b0);
      step();
      check("dn_q14", q, 4'd14);
      u_nd = 1'b1;
`endif

      // Cascade: two 4-bit stages behave as one 8-bit counter.
      c_nr = 1'b1; c_nload = 1'b0; c_d = 8'h0E; c_enp = 1'b1; c_ent = 1'b1;
      step();
      check("casc_load", {q_hi, q_lo}, 8'h0E);
      c_nload = 1'b1;
      step();
      check("casc_0f", {q_hi, q_lo}, 8'h0F);
      check("casc_0f_rco_lo", rco_lo, 1'b1);
      check("casc_0f_rco_hi", rco_hi, 1'b0);
      step();
      check("casc_10", {q_hi, q_lo}, 8'h10);
      step();
      check("casc_11", {q_hi, q_lo}, 8'h11);
      c_nload = 1'b0; c_d = 8'hFF;
      step();
      check("casc_ff_rco_lo", rco_lo, 1'b1);
      check("casc_ff_rco_hi", rco_hi, 1'b1);
      c_nload = 1'b1;
      step();
      check("casc_wrap", {q_hi, q_lo}, 8'h00);

      // Randomized run against the arithmetic model.
      model_q = q;
      model_c = {q_hi, q_lo};
      for (int i = 0; i < 400; i++) begin
         nr    = (i == 0) ? 1'b0 : ($urandom_range(0, 15) != 0);
         nload = ($urandom_range(0, 7) != 0);
         enp   = ($urandom_range(0, 3) != 0);
         ent   = ($urandom_range(0, 3) != 0);
         d     = 4'($urandom_range(0, 15));
`ifdef COUNTER_74163_UPDOWN_EN
         u_nd  = 1'($urandom_range(0, 1));
`endif
         c_nr    = (i == 0) ? 1'b0 : ($urandom_range(0, 15) != 0);
         c_nload = ($urandom_range(0, 15) != 0);
         c_enp   = ($urandom_range(0, 3) != 0);
         c_ent   = ($urandom_range(0, 7) != 0);
         c_d     = 8'($urandom_range(0, 255));
         model_q = model_next(model_q, nr, nload, enp, ent, int'(d), u_nd, 16);
         model_c = model_next(model_c, c_nr, c_nload, c_enp, c_ent, int'(c_d), 1'b1, 256);
         step();
         exp_r = ent && (u_nd ? (model_q == 15) : (model_q == 0));
         check($sformatf("rnd%0d_q", i), q, model_q);
         check($sformatf("rnd%0d_rco", i), rco, exp_r);
         check($sformatf("rnd%0d_casc", i), {q_hi, q_lo}, model_c);
         check($sformatf("rnd%0d_rco_lo", i), rco_lo, c_ent && ((model_c % 16) == 15));
         check($sformatf("rnd%0d_rco_hi", i), rco_hi, c_ent && (model_c == 255));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
